mux_n_1_scan: RTL and testbench
===============================

Name: mux_n_1_scan

Overview:
- Parametrised N-channel, multi-bit registered multiplexer; successor to the 2:1 combinational mux.
- Adds a registered output, two modes (manual select or automatic round-robin scan with programmable dwell), channel-change indication and illegal-select detection.
- Sits between parallel sample sources (sensors, counters, key inputs) and a single downstream consumer (display driver, UART framer).

Parameters:
DATA_W, 8, bit width of each channel.
CH_NUM, 4, number of input channels, legal range 2..16.
SEL_W, 2, select width; must equal ceil(log2(CH_NUM)).
DWELL, 10, clock cycles each channel is held in scan mode, legal range 1..65535.

Ports:
sys_clk  input  1  system clock, all logic on rising edge.
sys_rst  input  1  synchronous reset, active-high.
in_data  input  CH_NUM*DATA_W  packed channels; channel i at bits [i*DATA_W +: DATA_W].
sel      input  SEL_W  manual channel select.
mode     input  1  0 = manual, 1 = scan.
en       input  1  block enable.
out      output DATA_W  registered selected data.
out_ch   output SEL_W  channel index currently driven on out.
out_vld  output 1  out holds valid data this cycle.
ch_switch output 1  one-cycle pulse on first cycle of a new channel.
sel_err  output 1  one-cycle pulse: illegal sel sampled.

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high, and overrides all other inputs.
- Reset values: out=0, out_ch=0, out_vld=0, ch_switch=0, sel_err=0. Dwell counter is 0 and the state is IDLE.
- States: IDLE, MANUAL, SCAN. Next state is evaluated every cycle:
  - en=0 -> IDLE.
  - en=1 and mode=0 -> MANUAL.
  - en=1 and mode=1 -> SCAN.
- Latency: 1 cycle. out at edge k+1 = in_data channel cur_ch_next, sampled at edge k+1. Data and sel changes appear on out one cycle later.
- IDLE:
  - out and out_ch hold their values.
  - out_vld=0, ch_switch=0.
  - Dwell counter cleared to 0.
- MANUAL:
  - If sel < CH_NUM: cur_ch_next = sel.
  - Otherwise: cur_ch holds, and sel_err=1 in the following cycle. This case is only reachable when CH_NUM is not a power of 2.
  - Dwell counter held at 0.
- SCAN:
  - Dwell counter counts 0..DWELL-1.
  - At count DWELL-1: cur_ch increments (wrapping CH_NUM-1 -> 0) and the counter returns to 0.
  - DWELL=1 advances the channel every cycle.
  - sel is ignored; sel_err stays 0.
- Entering SCAN from MANUAL or IDLE:
  - Counter starts at 0.
  - Scan resumes from the current out_ch; there is no jump to 0.
  - The first advance happens DWELL cycles after entry.
- Leaving SCAN mid-dwell: the counter is discarded, and MANUAL takes sel at the next edge.
- out_vld = 1 in every cycle whose registered state is MANUAL or SCAN.
- ch_switch:
  - Asserted with out_vld=1 in the cycle out_ch takes a value different from its previous value.
  - Not asserted on re-selecting the same channel.
  - Not asserted on the first valid cycle after IDLE unless the channel changed.
- Channel data is not latched: out tracks the live in_data of the selected channel every enabled cycle.
- Simultaneous events: reset beats en, en beats mode, and a mode change beats dwell expiry.

Test Plan:
- Reset: hold sys_rst=1 for 3 cycles with arbitrary inputs -> out=0, out_ch=0, out_vld=0, ch_switch=0, sel_err=0.
- Manual select, DATA_W=8, CH_NUM=4: in_data={8'hD4,8'hC3,8'hB2,8'hA1}, en=1, mode=0, sel sequence 0,2,2,3 -> one cycle later:
  - out = A1, C3, C3, D4; out_ch = 0, 2, 2, 3.
  - ch_switch = 0, 1, 0, 1.
- Scan wrap, DWELL=3, CH_NUM=4: mode=1 from out_ch=2 -> out_ch sequence 2,2,2,3,3,3,0,0,0,1.
  - ch_switch pulses on the first 3, the first 0 and the first 1.
- Illegal select, CH_NUM=5, SEL_W=3: sel=1, then sel=6 for one cycle, then sel=4 -> out_ch=1, 1, 4; sel_err=1 for exactly one cycle after sel=6 was sampled.
- Enable/disable: in SCAN at count 1, drop en for 4 cycles while in_data changes -> out, out_ch frozen and out_vld=0. After re-enable, the next advance occurs a full DWELL cycles later.
- Mid-operation reset: assert sys_rst for 1 cycle during SCAN at out_ch=3 -> next cycle all outputs are 0 and the state is IDLE. With en=1, mode=1 held, scanning restarts from channel 0.

Source files
------------

// File: rtl/mux_n_1_scan.sv
// N-channel registered multiplexer with manual select or round-robin scan.
// Reports channel changes and out-of-range manual selects as one-cycle pulses.
module mux_n_1_scan #(
    parameter int DATA_W = 8,
    parameter int CH_NUM = 4,
    parameter int SEL_W  = 2,
    parameter int DWELL  = 10
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [CH_NUM*DATA_W-1:0]   in_data,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       mode,
    input  logic                       en,
    output logic [DATA_W-1:0]          out,
    output logic [SEL_W-1:0]           out_ch,
    output logic                       out_vld,
    output logic                       ch_switch,
    output logic                       sel_err
);

    localparam int               CH_SPAN    = 1 << SEL_W;
    localparam logic [SEL_W:0]   CH_LIMIT   = (SEL_W+1)'(CH_NUM);
    localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CH_NUM - 1);
    localparam logic [15:0]      DWELL_LAST = 16'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t              state_reg, state_next;
    logic [15:0]         cnt_reg, cnt_next;
    logic [SEL_W-1:0]    ch_reg, ch_next;
    logic [DATA_W-1:0]   out_reg, out_next;
    logic                vld_reg, vld_next;
    logic                sw_reg, sw_next;
    logic                err_reg, err_next;

    // Unpacked view of the inputs, padded to the full select range so any
    // index value is in bounds; pad entries are never selected.
    logic [DATA_W-1:0]   ch_data [CH_SPAN];

    generate
        for (genvar gi = 0; gi < CH_SPAN; gi++) begin : g_unpack
            if (gi < CH_NUM) begin : g_live
                assign ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign ch_data[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        if (!en)
            state_next = IDLE;
        else if (!mode)
            state_next = MANUAL;
        else
            state_next = SCAN;

        cnt_next = '0;
        ch_next  = ch_reg;
        out_next = out_reg;
        vld_next = 1'b0;
        sw_next  = 1'b0;
        err_next = 1'b0;

        case (state_next)
            MANUAL: begin
                vld_next = 1'b1;
                if ({1'b0, sel} < CH_LIMIT)
                    ch_next = sel;
                else
                    err_next = 1'b1;
                out_next = ch_data[ch_next];
                sw_next  = (ch_next != ch_reg);
            end
            SCAN: begin
                vld_next = 1'b1;
                // Entry cycle keeps the current channel with a fresh count.
                if (state_reg == SCAN) begin
                    if (cnt_reg == DWELL_LAST)
                        ch_next = (ch_reg == CH_LAST) ? '0 : ch_reg + 1'b1;
                    else
                        cnt_next = cnt_reg + 16'd1;
                end
                out_next = ch_data[ch_next];
                sw_next  = (ch_next != ch_reg);
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ch_reg    <= '0;
            out_reg   <= '0;
            vld_reg   <= 1'b0;
            sw_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ch_reg    <= ch_next;
            out_reg   <= out_next;
            vld_reg   <= vld_next;
            sw_reg    <= sw_next;
            err_reg   <= err_next;
        end
    end

    assign out       = out_reg;
    assign out_ch    = ch_reg;
    assign out_vld   = vld_reg;
    assign ch_switch = sw_reg;
    assign sel_err   = err_reg;

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Bench for mux_n_1_scan: a 4-channel DWELL=3 instance and a 5-channel
// DWELL=1 instance, each checked against a cycle model through a queue.
module tb_mux_n_1_scan;

    typedef struct {
        int         st;   // 0 idle, 1 manual, 2 scan
        int         cnt;
        int         ch;
        logic [7:0] out;
        logic       vld;
        logic       sw;
        logic       err;
    } model_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_mode, a_en;
    logic [31:0] a_in;
    logic [1:0]  a_sel;
    logic [7:0]  a_out;
    logic [1:0]  a_out_ch;
    logic        a_vld, a_sw, a_err;

    logic        b_rst, b_mode, b_en;
    logic [39:0] b_in;
    logic [2:0]  b_sel;
    logic [7:0]  b_out;
    logic [2:0]  b_out_ch;
    logic        b_vld, b_sw, b_err;

    mux_n_1_scan #(.DATA_W(8), .CH_NUM(4), .SEL_W(2), .DWELL(3)) dut_a (
        .sys_clk(clk), .sys_rst(a_rst), .in_data(a_in), .sel(a_sel),
        .mode(a_mode), .en(a_en), .out(a_out), .out_ch(a_out_ch),
        .out_vld(a_vld), .ch_switch(a_sw), .sel_err(a_err)
    );

    mux_n_1_scan #(.DATA_W(8), .CH_NUM(5), .SEL_W(3), .DWELL(1)) dut_b (
        .sys_clk(clk), .sys_rst(b_rst), .in_data(b_in), .sel(b_sel),
        .mode(b_mode), .en(b_en), .out(b_out), .out_ch(b_out_ch),
        .out_vld(b_vld), .ch_switch(b_sw), .sel_err(b_err)
    );

    int     checks   = 0;
    int     failures = 0;
    model_t ma, mb, ea, eb;
    model_t qa[$];
    model_t qb[$];
    int     scan_plan[10] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1};

    function automatic model_t model_step(model_t m, int ch_num, int dwell,
                                          logic rst, logic en, logic mode,
                                          int sel, logic [127:0] data);
        model_t n;
        n = m;
        if (rst) begin
            n.st = 0; n.cnt = 0; n.ch = 0; n.out = 8'h00;
            n.vld = 1'b0; n.sw = 1'b0; n.err = 1'b0;
        end else if (!en) begin
            n.st = 0; n.cnt = 0; n.vld = 1'b0; n.sw = 1'b0; n.err = 1'b0;
        end else if (!mode) begin
            n.st  = 1;
            n.cnt = 0;
            n.vld = 1'b1;
            n.err = (sel >= ch_num);
            if (sel < ch_num) n.ch = sel;
            n.sw  = (n.ch != m.ch);
            n.out = data[n.ch*8 +: 8];
        end else begin
            n.vld = 1'b1;
            n.err = 1'b0;
            if (m.st == 2) begin
                if (m.cnt == dwell - 1) begin
                    n.ch  = (m.ch + 1) % ch_num;
                    n.cnt = 0;
                end else begin
                    n.cnt = m.cnt + 1;
                end
            end else begin
                n.cnt = 0;
            end
            n.st  = 2;
            n.sw  = (n.ch != m.ch);
            n.out = data[n.ch*8 +: 8];
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        ma = model_step(ma, 4, 3, a_rst, a_en, a_mode, int'(a_sel), 128'(a_in));
        qa.push_back(ma);
        mb = model_step(mb, 5, 1, b_rst, b_en, b_mode, int'(b_sel), 128'(b_in));
        qb.push_back(mb);
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_out", 32'(a_out), 32'(ea.out));
        check("a_out_ch", 32'(a_out_ch), 32'(ea.ch));
        check("a_out_vld", 32'(a_vld), 32'(ea.vld));
        check("a_ch_switch", 32'(a_sw), 32'(ea.sw));
        check("a_sel_err", 32'(a_err), 32'(ea.err));
        check("b_out", 32'(b_out), 32'(eb.out));
        check("b_out_ch", 32'(b_out_ch), 32'(eb.ch));
        check("b_out_vld", 32'(b_vld), 32'(eb.vld));
        check("b_ch_switch", 32'(b_sw), 32'(eb.sw));
        check("b_sel_err", 32'(b_err), 32'(eb.err));
        $display("cyc a: rst=%0b en=%0b mode=%0b sel=%0d -> out=%h ch=%0d vld=%0b sw=%0b err=%0b | b: sel=%0d -> out=%h ch=%0d vld=%0b sw=%0b err=%0b",
                 a_rst, a_en, a_mode, a_sel, a_out, a_out_ch, a_vld, a_sw, a_err,
                 b_sel, b_out, b_out_ch, b_vld, b_sw, b_err);
    endtask

    initial begin
        ma = '{st: 0, cnt: 0, ch: 0, out: 8'h00, vld: 1'b0, sw: 1'b0, err: 1'b0};
        mb = ma;

        // Reset with arbitrary inputs
        a_rst = 1'b1; a_en = 1'b1; a_mode = 1'b1; a_sel = 2'd3; a_in = $urandom;
        b_rst = 1'b1; b_en = 1'b1; b_mode = 1'b0; b_sel = 3'd2; b_in = {$urandom, $urandom};
        repeat (3) tick();
        check("a_reset_out", 32'(a_out), 32'h0);
        check("a_reset_vld", 32'(a_vld), 32'h0);

        // Manual select on A
        a_rst = 1'b0; b_rst = 1'b0; b_en = 1'b0;
        a_en = 1'b1; a_mode = 1'b0; a_in = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        a_sel = 2'd0; tick();
        a_sel = 2'd2; tick();
        check("plan_manual_out", 32'(a_out), 32'hC3);
        a_sel = 2'd2; tick();
        check("plan_manual_nosw", 32'(a_sw), 32'h0);
        a_sel = 2'd3; tick();
        check("plan_manual_d4", 32'(a_out), 32'hD4);

        // Scan wrap from channel 2 with live data
        a_sel = 2'd2; tick();
        a_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_in = $urandom;
            a_sel = 2'($urandom);
            tick();
            check("plan_scan_ch", 32'(a_out_ch), 32'(scan_plan[i]));
        end

        // Disable at count 1 while data changes, then re-enable
        tick();
        a_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_in = $urandom;
            tick();
        end
        a_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_in = $urandom;
            tick();
        end

        // Mid-operation reset at channel 3, scan restarts from 0
        for (int i = 0; i < 12 && ma.ch != 3; i++) tick();
        check("a_reached_ch3", 32'(a_out_ch), 32'd3);
        a_rst = 1'b1; tick();
        a_rst = 1'b0;
        repeat (4) tick();

        // Mode change at dwell expiry keeps the manual channel
        tick(); tick();
        a_mode = 1'b0; a_sel = a_out_ch; tick();
        check("a_mode_beats_expiry", 32'(a_sw), 32'h0);

        // Illegal select on B (5 channels)
        b_en = 1'b1; b_mode = 1'b0; b_in = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        b_sel = 3'd1; tick();
        b_sel = 3'd6; tick();
        check("plan_illegal_ch", 32'(b_out_ch), 32'd1);
        check("plan_illegal_err", 32'(b_err), 32'd1);
        b_sel = 3'd4; tick();
        check("plan_illegal_ch4", 32'(b_out_ch), 32'd4);
        check("plan_illegal_err_clear", 32'(b_err), 32'd0);

        // DWELL=1 scan advances every cycle and wraps 4 -> 0
        b_mode = 1'b1; b_sel = 3'd7;
        repeat (7) tick();
        // en has priority over mode
        b_en = 1'b0; tick();
        b_en = 1'b1; b_mode = 1'b0; b_sel = 3'd5; tick();

        // Random mixed traffic on both instances
        for (int i = 0; i < 300; i++) begin
            a_rst  = ($urandom_range(0, 39) == 0);
            b_rst  = ($urandom_range(0, 39) == 0);
            a_en   = ($urandom_range(0, 7) != 0);
            b_en   = ($urandom_range(0, 7) != 0);
            a_mode = ($urandom_range(0, 3) != 0);
            b_mode = ($urandom_range(0, 1) != 0);
            a_sel  = 2'($urandom);
            b_sel  = 3'($urandom);
            a_in   = $urandom;
            b_in   = {$urandom, $urandom};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
